vault_mem_arbiter: RTL and testbench

- Arbitrates the single-port 16x256 password-vault RAM between two requesters.
  - Port 0: crypto/boot engine.
  - Port 1: host loader.
- Sequences each access as a fixed multi-cycle transaction and bounds-checks addresses against the live `max_address`.
- Sits between the requesters and the RAM instance inside the hardware wrapper.

---
 rtl/vault_pkg.sv | 18 +
 rtl/vault_arb_pick.sv | 31 +++
 rtl/vault_mem_arbiter.sv | 132 +++++++++++++
 tb/tb_vault_mem_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/vault_pkg.sv
// Shared types and constants for the password-vault RAM arbiter.
// The optional round-robin mode is selected with VAULT_ARB_ROUND_ROBIN_EN.
package vault_pkg;

    localparam int VAULT_ADDR_W = 4;
    localparam int VAULT_DATA_W = 256;

    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_HOST = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } vault_state_t;

endpackage

// File: rtl/vault_arb_pick.sv
// Combinational winner select between the two vault requesters.
// VAULT_ARB_ROUND_ROBIN_EN selects round-robin; otherwise port 0 has fixed priority.
module vault_arb_pick
    import vault_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic any,
    output logic win
);

    assign any = req0 | req1;

`ifdef VAULT_ARB_ROUND_ROBIN_EN
    // On a tie the port that did not win last time is favoured.
    always_comb begin
        win = PORT_CORE;
        if (req0 && req1) begin
            win = ~last;
        end else if (req1) begin
            win = PORT_HOST;
        end
    end
`else
    logic unused_last;
    assign unused_last = last;
    assign win = (req0 || !req1) ? PORT_CORE : PORT_HOST;
`endif

endmodule

// File: rtl/vault_mem_arbiter.sv
// Two-port arbiter for the single-port 16x256 vault RAM; each access is a fixed
// IDLE->ACCESS->CAPTURE->DONE sequence. Arbitration mode: VAULT_ARB_ROUND_ROBIN_EN.
module vault_mem_arbiter
    import vault_pkg::*;
#(
    parameter int ADDR_W = VAULT_ADDR_W,
    parameter int DATA_W = VAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic              p0_err,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic              p1_err,
    output logic [DATA_W-1:0] p1_rdata,
    input  logic [ADDR_W-1:0] max_address,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_q,
    output logic              busy,
    output logic              owner,
    output vault_state_t      dbg_state
);

    // Handshake: a requester raises req with stable we/addr/wdata and holds them
    // until its one-cycle ack; ack (with err) is the only completion signal, and
    // a req still high in the IDLE after DONE is taken as a new transaction.

    vault_state_t state, state_next;

    logic              last_grant;
    logic              we_q;
    logic              err_q;
    logic              pick_any;
    logic              pick_win;
    logic              grant;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_legal;

    vault_arb_pick u_pick (
        .req0 (p0_req),
        .req1 (p1_req),
        .last (last_grant),
        .any  (pick_any),
        .win  (pick_win)
    );

    assign sel_we    = (pick_win == PORT_HOST) ? p1_we    : p0_we;
    assign sel_addr  = (pick_win == PORT_HOST) ? p1_addr  : p0_addr;
    assign sel_wdata = (pick_win == PORT_HOST) ? p1_wdata : p0_wdata;
    assign sel_legal = (sel_addr <= max_address);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        grant      = 1'b0;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    grant      = 1'b1;
                    state_next = sel_legal ? ACCESS : DONE;
                end
            end
            ACCESS:  state_next = CAPTURE;
            CAPTURE: state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Memory-side registers only move on a legal grant, so they hold outside ACCESS.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= PORT_HOST;
            owner      <= PORT_CORE;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            mem_addr   <= '0;
            mem_we     <= 1'b0;
            mem_wdata  <= '0;
            p0_rdata   <= '0;
            p1_rdata   <= '0;
        end else begin
            mem_we <= 1'b0;
            if (grant) begin
                owner      <= pick_win;
                last_grant <= pick_win;
                we_q       <= sel_we;
                err_q      <= !sel_legal;
                if (sel_legal) begin
                    mem_addr  <= sel_addr;
                    mem_we    <= sel_we;
                    mem_wdata <= sel_wdata;
                end
            end
            if (state == CAPTURE && !we_q) begin
                if (owner == PORT_HOST) begin
                    p1_rdata <= mem_q;
                end else begin
                    p0_rdata <= mem_q;
                end
            end
        end
    end

    assign p0_ack    = (state == DONE) && (owner == PORT_CORE);
    assign p1_ack    = (state == DONE) && (owner == PORT_HOST);
    assign p0_err    = p0_ack && err_q;
    assign p1_err    = p1_ack && err_q;
    assign busy      = (state != IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_vault_mem_arbiter.sv
// Directed bench for vault_mem_arbiter with a behavioural 16x256 RAM model.
// Grant-order expectations follow VAULT_ARB_ROUND_ROBIN_EN when defined.
module tb_vault_mem_arbiter;
    import vault_pkg::*;

    localparam int AW = 4;
    localparam int DW = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic          p0_req, p0_we, p1_req, p1_we;
    logic [AW-1:0] p0_addr, p1_addr, max_address;
    logic [DW-1:0] p0_wdata, p1_wdata;
    logic          p0_ack, p0_err, p1_ack, p1_err;
    logic [DW-1:0] p0_rdata, p1_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata, mem_q;
    logic          busy, owner;
    vault_state_t  dbg_state;

    logic [DW-1:0] ram [16];
    logic [0:0]    exp_q [$];

    int n_pass  = 0;
    int n_total = 0;

    localparam logic [DW-1:0] PAT_A5 = {32{8'hA5}};
    localparam logic [DW-1:0] PAT_DB = {8{32'hDEADBEEF}};

    vault_mem_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .p0_req      (p0_req),
        .p0_we       (p0_we),
        .p0_addr     (p0_addr),
        .p0_wdata    (p0_wdata),
        .p0_ack      (p0_ack),
        .p0_err      (p0_err),
        .p0_rdata    (p0_rdata),
        .p1_req      (p1_req),
        .p1_we       (p1_we),
        .p1_addr     (p1_addr),
        .p1_wdata    (p1_wdata),
        .p1_ack      (p1_ack),
        .p1_err      (p1_err),
        .p1_rdata    (p1_rdata),
        .max_address (max_address),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_q       (mem_q),
        .busy        (busy),
        .owner       (owner),
        .dbg_state   (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    // RAM model: synchronous write, read data one cycle after the address.
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_q <= ram[mem_addr];
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic st(input string tag, input vault_state_t exp);
        check(tag, DW'(dbg_state), DW'(exp));
    endtask

    initial begin
        logic [0:0] exp_port;
        int         got;
        bit         seen;

        rst = 1'b1;
        p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
        p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
        max_address = 4'd9;
        step(); step();
        rst = 1'b0;
        check("reset_busy", DW'(busy), 0);
        check("reset_ack", DW'({p0_ack, p1_ack, p0_err, p1_err}), 0);
        check("reset_mem", DW'({mem_we, mem_addr, owner}), 0);
        check("reset_rdata", p0_rdata | p1_rdata, 0);
        st("reset_state", IDLE);

        // port 0 write addr 3
        p0_req = 1; p0_we = 1; p0_addr = 4'd3; p0_wdata = PAT_A5;
        step();
        check("wr_we_t1", DW'(mem_we), 1);
        check("wr_addr_t1", DW'(mem_addr), 3);
        check("wr_data_t1", mem_wdata, PAT_A5);
        check("wr_busy_t1", DW'(busy), 1);
        step();
        check("wr_we_t2", DW'(mem_we), 0);
        check("wr_ack_t2", DW'(p0_ack), 0);
        step();
        check("wr_ack_t3", DW'({p0_ack, p0_err}), 2'b10);
        check("wr_rdata_kept", p0_rdata, 0);
        p0_req = 0;
        step();
        st("wr_back_idle", IDLE);
        check("wr_ack_once", DW'(p0_ack), 0);

        // port 1 read addr 3
        p1_req = 1; p1_we = 0; p1_addr = 4'd3;
        step();
        check("rd_we_t1", DW'(mem_we), 0);
        check("rd_owner", DW'(owner), 1);
        step(); step();
        check("rd_ack_t3", DW'({p1_ack, p1_err, p0_ack}), 3'b100);
        check("rd_data", p1_rdata, PAT_A5);
        p1_req = 0;
        step();

        // port 0 out-of-range read
        p0_req = 1; p0_we = 0; p0_addr = 4'd12;
        step();
        check("err_ack_t1", DW'({p0_ack, p0_err}), 2'b11);
        check("err_no_we", DW'(mem_we), 0);
        check("err_addr_held", DW'(mem_addr), 3);
        check("err_rdata_kept", p0_rdata, 0);
        p0_req = 0;
        step();

        // both ports requesting continuously, starting from a fresh pointer
        rst = 1; step(); rst = 0;
`ifdef VAULT_ARB_ROUND_ROBIN_EN
        exp_q = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_q = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        p0_req = 1; p0_we = 0; p0_addr = 4'd3;
        p1_req = 1; p1_we = 0; p1_addr = 4'd5;
        got = 0;
        for (int i = 0; i < 40 && got < 4; i++) begin
            step();
            check("one_ack", DW'(p0_ack && p1_ack), 0);
            if (p0_ack || p1_ack) begin
                exp_port = exp_q.pop_front();
                check("grant_order", DW'(p1_ack), DW'(exp_port));
                got++;
                if (got == 4) p0_req = 0;
            end
        end
        check("grant_count", DW'(got), 4);
        check("arb_p0_data", p0_rdata, PAT_A5);
        seen = 0;
        for (int i = 0; i < 12 && !seen; i++) begin
            step();
            if (p1_ack) seen = 1;
        end
        check("host_served", DW'(seen), 1);
        p1_req = 0;
        step(); step();
        st("arb_idle", IDLE);

        // reset during CAPTURE of a read
        max_address = 4'd9;
        p0_req = 1; p0_we = 0; p0_addr = 4'd3;
        step();
        st("rst_access", ACCESS);
        step();
        st("rst_capture", CAPTURE);
        rst = 1; p0_req = 0;
        step();
        st("rst_state", IDLE);
        check("rst_outs", DW'({p0_ack, p0_err, p1_ack, p1_err, busy, owner, mem_we}), 0);
        check("rst_mem", DW'(mem_addr) | mem_wdata, 0);
        check("rst_rdata", p0_rdata | p1_rdata, 0);
        rst = 0;
        step(); step();
        check("rst_no_ack", DW'({p0_ack, p1_ack, busy}), 0);

        // boundary: address 15 with max_address 15
        max_address = 4'd15;
        p1_req = 1; p1_we = 1; p1_addr = 4'd15; p1_wdata = PAT_DB;
        step();
        check("b15_we", DW'({mem_we, mem_addr}), {1'b1, 4'd15});
        step(); step();
        check("b15_ack", DW'({p1_ack, p1_err}), 2'b10);
        p1_req = 0;
        step();

        // read addr 15; max_address drops mid-transaction and must be ignored
        p0_req = 1; p0_we = 0; p0_addr = 4'd15;
        step();
        max_address = 4'd0;
        step(); step();
        check("b15_rd_ack", DW'({p0_ack, p0_err}), 2'b10);
        check("b15_rd_data", p0_rdata, PAT_DB);
        p0_req = 0;
        step();

        // boundary: max_address 0
        p0_req = 1; p0_addr = 4'd1;
        step();
        check("m0_a1_err", DW'({p0_ack, p0_err, mem_we}), 3'b110);
        check("m0_a1_rdata", p0_rdata, PAT_DB);
        p0_req = 0;
        step();
        p0_req = 1; p0_addr = 4'd0;
        step();
        st("m0_a0_access", ACCESS);
        step(); step();
        check("m0_a0_ack", DW'({p0_ack, p0_err}), 2'b10);
        p0_req = 0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
